// File: rtl/mem_stage.sv
// mem_stage
// ---------
// Memory stage of the five-stage ARM pipeline. The ALU result coming out of
// execute is used as the byte address into a word-addressed data memory, and
// Rm is used as the store data. Every load or store takes WAIT_CYCLES cycles
// in the BUSY state. While an access is pending, freeze stalls IF, ID and EX.
// When the access completes, its results land in the MEM/WB register.
//
// Parameters:
//   DEPTH        data memory size in 32-bit words
//   BASE_ADDR    byte address that maps to word 0
//   WAIT_CYCLES  access latency in cycles (1..15)
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   wb_en_in          instruction writes the register file
//   mem_R_en          load request
//   mem_W_en          store request
//   alu_result        byte address for loads/stores, result otherwise
//   val_rm            store data
//   dest_in           destination register
//   freeze            stall toward IF/ID/EX
//   wb_en_out         registered write enable toward WB
//   mem_R_en_out      registered load flag (selects mem_result_out in WB)
//   alu_result_out    registered ALU result
//   mem_result_out    registered load data
//   dest_out          registered destination register
//   align_err         one-cycle misalignment pulse (only with the macro)
//
// Optional feature:
//   MEM_ALIGN_CHECK_EN  when this macro is defined, a misaligned request
//                       still runs through the full FSM timing, but no
//                       store is written and the load data is 0. The
//                       align_err pulse is raised for that request.

module mem_stage #(
   parameter int DEPTH       = 64,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_en_in,
   input  logic        mem_R_en,
   input  logic        mem_W_en,
   input  logic [31:0] alu_result,
   input  logic [31:0] val_rm,
   input  logic [3:0]  dest_in,
   output logic        freeze,
   output logic        wb_en_out,
   output logic        mem_R_en_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] mem_result_out,
   output logic [3:0]  dest_out
`ifdef MEM_ALIGN_CHECK_EN
   ,
   output logic        align_err
`endif
);

   localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] read_reg;
   logic [31:0] index;
   logic        req;
   logic        in_range;
   logic        access_ok;
   logic        commit;

   logic [31:0] mem [DEPTH];

   assign req      = mem_R_en | mem_W_en;
   assign index    = (alu_result - 32'(BASE_ADDR)) >> 2;
   assign in_range = index < 32'(DEPTH);

`ifdef MEM_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = alu_result[1:0] != 2'b00;
   assign access_ok  = in_range && !misaligned;
`else
   assign access_ok  = in_range;
`endif

   // The access takes effect on the edge that leaves BUSY with cnt == 1.
   assign commit = (state == BUSY) && (cnt == 4'd1);

   // The stall is raised combinationally as soon as a request shows up in IDLE.
   // This stops the upstream stages on the same edge that starts the access.
   always_comb begin
      freeze = 1'b0;
      if (state == BUSY || (state == IDLE && req))
         freeze = 1'b1;
   end

   // The data memory is not reset. Reset does block the write, though, so an
   // aborted store never reaches the array. A store has priority over a load
   // when both request bits are set.
   always_ff @(posedge clk) begin
      if (!rst && commit && mem_W_en && access_ok)
         mem[index[AW-1:0]] <= val_rm;
   end

   // Access FSM: IDLE -> BUSY (counts down) -> DONE (single unstalled cycle).
   // The load result is captured into read_reg at the commit edge, so DONE
   // can hand it to the WB register while the inputs are still the same request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         read_reg <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  cnt   <= WAIT_INIT;
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (commit) begin
                  read_reg <= (mem_R_en && !mem_W_en && access_ok) ?
                              mem[index[AW-1:0]] : 32'd0;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // MEM/WB register. While frozen, a bubble is injected by clearing the two
   // control bits, and the data fields hold their values. When not frozen,
   // every field loads from the inputs. The load data is only meaningful in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_out      <= 1'b0;
         mem_R_en_out   <= 1'b0;
         alu_result_out <= 32'd0;
         mem_result_out <= 32'd0;
         dest_out       <= 4'd0;
      end else if (freeze) begin
         wb_en_out      <= 1'b0;
         mem_R_en_out   <= 1'b0;
      end else begin
         wb_en_out      <= wb_en_in;
         mem_R_en_out   <= mem_R_en;
         alu_result_out <= alu_result;
         mem_result_out <= (state == DONE) ? read_reg : 32'd0;
         dest_out       <= dest_in;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   // The pulse lines up with the DONE-cycle WB capture of the offending request.
   always_ff @(posedge clk) begin
      if (rst)
         align_err <= 1'b0;
      else
         align_err <= (state == DONE) && req && misaligned;
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// ------------
// Testbench for mem_stage. It runs a list of directed sequences and then
// random instructions. A behavioural model of the memory stage lives in the
// bench: an array holding the memory contents, plus the timeline each
// instruction should follow. The outputs are compared against this model on
// every cycle. A few literal expectations pin the model to known values.
// Build with +define+MEM_ALIGN_CHECK_EN to exercise the alignment check.

module tb_mem_stage;

   localparam int DEPTH = 64;
   localparam int BASE  = 1024;
   localparam int WAIT  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en_in;
   logic        mem_R_en;
   logic        mem_W_en;
   logic [31:0] alu_result;
   logic [31:0] val_rm;
   logic [3:0]  dest_in;
   logic        freeze;
   logic        wb_en_out;
   logic        mem_R_en_out;
   logic [31:0] alu_result_out;
   logic [31:0] mem_result_out;
   logic [3:0]  dest_out;
`ifdef MEM_ALIGN_CHECK_EN
   logic        align_err;
`endif

   always #5 clk = ~clk;

   mem_stage #(
      .DEPTH       (DEPTH),
      .BASE_ADDR   (BASE),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .wb_en_in       (wb_en_in),
      .mem_R_en       (mem_R_en),
      .mem_W_en       (mem_W_en),
      .alu_result     (alu_result),
      .val_rm         (val_rm),
      .dest_in        (dest_in),
      .freeze         (freeze),
      .wb_en_out      (wb_en_out),
      .mem_R_en_out   (mem_R_en_out),
      .alu_result_out (alu_result_out),
      .mem_result_out (mem_result_out),
      .dest_out       (dest_out)
`ifdef MEM_ALIGN_CHECK_EN
      ,
      .align_err      (align_err)
`endif
   );

   int checks = 0;
   int errors = 0;
   int freeze_hi = 0;

   // Model state: the memory contents and the expected outputs.
   logic [31:0] model_mem [DEPTH];
   logic        exp_freeze;
   logic        e_wb;
   logic        e_rd;
   logic        e_align;
   logic [31:0] e_alu;
   logic [31:0] e_mem;
   logic [3:0]  e_dest;

   // Compares one value against its expectation and records a failure if they differ.
   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Compares all outputs against the model for the current cycle.
   task automatic checkOutput();
      checkValue("freeze",         32'(freeze),         32'(exp_freeze));
      checkValue("wb_en_out",      32'(wb_en_out),      32'(e_wb));
      checkValue("mem_R_en_out",   32'(mem_R_en_out),   32'(e_rd));
      checkValue("alu_result_out", alu_result_out,      e_alu);
      checkValue("mem_result_out", mem_result_out,      e_mem);
      checkValue("dest_out",       32'(dest_out),       32'(e_dest));
`ifdef MEM_ALIGN_CHECK_EN
      checkValue("align_err",      32'(align_err),      32'(e_align));
`endif
   endtask

   // Returns 1 when a misaligned access must be suppressed.
   function automatic logic suppressed(input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
      return addr[1:0] != 2'b00;
`else
      return 1'b0 & addr[0];
`endif
   endfunction

   // Presents one instruction and holds it for its full duration. A memory
   // request lasts WAIT+2 cycles: WAIT+1 frozen cycles followed by DONE. Any
   // other instruction lasts a single cycle. The expected outputs are advanced
   // after every edge.
   task automatic applyStimulus(input logic rd, input logic wr, input logic wb,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] dest);
      logic        req;
      logic [31:0] idx;
      logic        ok;
      logic [31:0] ld;
      int          ncyc;
      req        = rd | wr;
      mem_R_en   = rd;
      mem_W_en   = wr;
      wb_en_in   = wb;
      alu_result = addr;
      val_rm     = data;
      dest_in    = dest;
      idx  = (addr - 32'(BASE)) >> 2;
      ok   = (idx < 32'(DEPTH)) && !suppressed(addr);
      ld   = (rd && !wr && ok) ? model_mem[idx[5:0]] : 32'd0;
      ncyc = req ? WAIT + 2 : 1;
      for (int k = 0; k < ncyc; k++) begin
         exp_freeze = req && (k <= WAIT);
         @(negedge clk);
         checkOutput();
         if (freeze) freeze_hi++;
         @(posedge clk);
         #2;
         if (exp_freeze) begin
            e_wb    = 1'b0;
            e_rd    = 1'b0;
            e_align = 1'b0;
         end else begin
            e_wb    = wb;
            e_rd    = rd;
            e_alu   = addr;
            e_dest  = dest;
            e_mem   = req ? ld : 32'd0;
            e_align = req && suppressed(addr);
         end
      end
      if (wr && ok) model_mem[idx[5:0]] = data;
   endtask

   // Sets the model to its reset state. The memory contents are left untouched.
   task automatic resetModel();
      exp_freeze = 1'b0;
      e_wb    = 1'b0;
      e_rd    = 1'b0;
      e_align = 1'b0;
      e_alu   = 32'd0;
      e_mem   = 32'd0;
      e_dest  = 4'd0;
   endtask

   initial begin
      int          s;
      logic [31:0] addr;
      int          kind;
      int          sel;

      rst        = 1'b1;
      wb_en_in   = 1'b0;
      mem_R_en   = 1'b0;
      mem_W_en   = 1'b0;
      alu_result = 32'd0;
      val_rm     = 32'd0;
      dest_in    = 4'd0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
      resetModel();

      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;

      // Reset state.
      checkValue("reset_freeze",     32'(freeze),       32'd0);
      checkValue("reset_wb_en",      32'(wb_en_out),    32'd0);
      checkValue("reset_mem_R_en",   32'(mem_R_en_out), 32'd0);
      checkValue("reset_alu_result", alu_result_out,    32'd0);
      checkValue("reset_mem_result", mem_result_out,    32'd0);
      checkValue("reset_dest",       32'(dest_out),     32'd0);

      // Zero the whole memory through ordinary stores.
      for (int i = 0; i < DEPTH; i++)
         applyStimulus(1'b0, 1'b1, 1'b0, 32'(BASE + 4 * i), 32'd0, 4'd0);

      // Pass-through ADD.
      s = freeze_hi;
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h55, 32'd0, 4'd3);
      checkValue("add_alu_result", alu_result_out,        32'h55);
      checkValue("add_dest",       32'(dest_out),         32'd3);
      checkValue("add_wb_en",      32'(wb_en_out),        32'd1);
      checkValue("add_no_freeze",  32'(freeze_hi - s),    32'd0);

      // Store then load.
      s = freeze_hi;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0);
      checkValue("store_freeze_cycles", 32'(freeze_hi - s), 32'd3);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd5);
      checkValue("load_1028",      mem_result_out,     32'hDEADBEEF);
      checkValue("load_mem_R_en",  32'(mem_R_en_out),  32'd1);

      // Out of range.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'(BASE + 256), 32'd7, 4'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'(BASE + 256), 32'd0, 4'd6);
      checkValue("load_out_of_range", mem_result_out, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'(BASE), 32'd0, 4'd6);
      checkValue("load_word0_untouched", mem_result_out, 32'd0);

      // Back-to-back load then store.
      s = freeze_hi;
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd1036, 32'h77, 4'd0);
      checkValue("b2b_freeze_cycles", 32'(freeze_hi - s), 32'd6);

      // Reset during the BUSY state of a store to 1032 aborts the write.
      mem_R_en   = 1'b0;
      mem_W_en   = 1'b1;
      wb_en_in   = 1'b0;
      alu_result = 32'd1032;
      val_rm     = 32'h1234;
      dest_in    = 4'd0;
      @(posedge clk);
      #2;
      rst        = 1'b1;
      mem_W_en   = 1'b0;
      alu_result = 32'd0;
      val_rm     = 32'd0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      resetModel();
      checkValue("abort_freeze",   32'(freeze), 32'd0);
      checkValue("abort_alu_zero", alu_result_out, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd1);
      checkValue("load_after_abort", mem_result_out, 32'd0);

      // Misaligned store.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd1030, 32'h0000A5A5, 4'd0);
`ifdef MEM_ALIGN_CHECK_EN
      checkValue("misaligned_align_err", 32'(align_err), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd1);
      checkValue("misaligned_no_write", mem_result_out, 32'hDEADBEEF);
`else
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd1);
      checkValue("misaligned_writes_word1", mem_result_out, 32'h0000A5A5);
`endif

      // Random instruction mix.
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 7);
         sel  = $urandom_range(0, 9);
         if (sel < 7)      addr = 32'(BASE + 4 * $urandom_range(0, 69));
         else if (sel == 7) addr = 32'(BASE + $urandom_range(0, 255));
         else if (sel == 8) addr = $urandom;
         else               addr = 32'(BASE - 4 * $urandom_range(1, 4));
         case (kind)
            0, 1:    applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            2, 3, 4: applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
            5, 6:    applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
            default: applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
         endcase
      end

      // Final cycle with the last expectation.
      mem_R_en = 1'b0;
      mem_W_en = 1'b0;
      exp_freeze = 1'b0;
      @(negedge clk);
      checkOutput();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage ARM pipeline, consuming the execute stage's ALU result as the data-memory address and its Rm value as the store data. It owns a word-addressed data memory with a configurable access latency and raises a `freeze` stall to the upstream stages until each access completes. Results are registered into the MEM/WB pipeline register that drives write-back.

## Interface
- `DEPTH`, 64: data memory size in 32-bit words.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `WAIT_CYCLES`, 2: access latency in cycles. Legal range is 1..15.
- `clk` input 1: clock; every register updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `wb_en_in` input 1: instruction writes the register file.
- `mem_R_en` input 1: load request.
- `mem_W_en` input 1: store request.
- `alu_result` input 32: byte address for loads/stores; the result for non-memory instructions.
- `val_rm` input 32: store data.
- `dest_in` input 4: destination register.
- `freeze` output 1: stalls the IF, ID and EX stages and their pipeline registers.
- `wb_en_out` output 1: registered write enable toward WB.
- `mem_R_en_out` output 1: registered load flag; selects the memory result in WB.
- `alu_result_out` output 32: registered ALU result.
- `mem_result_out` output 32: registered load data.
- `dest_out` output 4: registered destination register.
- `align_err` output 1: registered misalignment pulse; present only with the macro.

## Operation
- A request exists when `mem_R_en | mem_W_en` is high.
- Word index is `(alu_result - BASE_ADDR) >> 2`, computed as 32-bit unsigned.
- An index ≥ `DEPTH` is out of range: a store is dropped, a load returns 0.
- Memory contents are not reset; the bench initialises them to 0.
- FSM states are IDLE, BUSY and DONE, with a 4-bit down counter `cnt`.
- IDLE without a request:
  - `freeze`=0.
  - Non-memory instructions pass straight through to the WB registers.
- IDLE with a request:
  - `freeze`=1 combinationally.
  - `cnt`←`WAIT_CYCLES`, go to BUSY.
- BUSY:
  - `freeze`=1 and `cnt` decrements each cycle.
  - On the edge leaving `cnt`==1, the store commits or the load data is captured into an internal read register, then go to DONE.
- DONE:
  - `freeze`=0 for exactly one cycle.
  - The inputs still present are the completed request. They are not re-issued; they are captured into the WB registers together with the read register.
  - Next state is IDLE.
- If `mem_R_en` and `mem_W_en` are both high, the store is performed and the load data is 0. `mem_R_en_out` still reflects the input.
- The inputs are held stable by `freeze` throughout BUSY.
- WB register update:
  - When `freeze`=0, all `*_out` registers load from the inputs; `mem_result_out` loads the read register in DONE and 0 otherwise.
  - When `freeze`=1, `wb_en_out` and `mem_R_en_out` load 0 (bubble), and the other outputs hold.

## Timing
- Reset values: state=IDLE, `cnt`=0, all `*_out`=0, `align_err`=0, read register=0. `freeze`=0 after reset.
- Non-memory instruction: zero stall cycles; outputs are valid one edge after it is presented.
- Memory instruction presented at cycle t:
  - `freeze` is high for cycles t..t+`WAIT_CYCLES`, i.e. `WAIT_CYCLES`+1 cycles.
  - DONE is at t+`WAIT_CYCLES`+1.
  - WB outputs are valid after that edge.
- A memory request arriving in the cycle right after DONE is accepted in IDLE with no extra gap cycle.
- Reset asserted in BUSY aborts the access: a store whose commit edge has not occurred is not written. The next state is IDLE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A request with `alu_result[1:0]`≠0 is suppressed: no store, load data 0.
  - The request still goes through the full FSM timing.
  - `align_err` pulses high for one cycle, coincident with the DONE-cycle WB capture.
- Not defined:
  - `alu_result[1:0]` is ignored by the index computation.
  - The `align_err` port is absent.

## Test plan
- **Reset and pass-through:** reset for 2 cycles → all outputs 0. Then an ADD with `alu_result`=0x55, `dest_in`=3, `wb_en_in`=1 → next edge `alu_result_out`=0x55, `dest_out`=3, `wb_en_out`=1, `freeze` never high.
- **Store then load:** with `WAIT_CYCLES`=2, store 0xDEADBEEF to 1028 → `freeze` high 3 cycles, then low. Then load from 1028 → `mem_result_out`=0xDEADBEEF, `mem_R_en_out`=1.
- **Bubbles during stall:** during the load's freeze, `wb_en_out`=0 every cycle.
- **Out of range:** with `DEPTH`=64, store 7 to 1024+256 → memory unchanged; a load from the same address returns 0.
- **Back-to-back and reset abort:**
  - Load immediately followed by store → second request accepted the cycle after DONE, total `freeze`-high cycles = 6.
  - Assert `rst` during BUSY of a store of 0x1234 to 1032 → a later load of 1032 returns 0.
- **Misaligned access (macro defined):** store to 1030 → `align_err` one-cycle pulse, no memory write. With the macro undefined, the same store writes word 1.
